// File: rtl/vga_capture.sv
// ---------------------------------------------------------------------------
// vga_capture
//
// Receive side of a VGA pixel interface running in the pixel clock domain.
// Samples hsync/vsync/RGB444, recovers pixel coordinates, verifies line and
// frame periods and, once the timing has been seen to be stable for
// LOCK_FRAMES consecutive frames, emits a tagged pixel stream.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   red/green/blue  4-bit colour channels
//   pixel_valid  pixel_x/pixel_y/pixel_color valid this cycle
//   pixel_x      active column, 0..H_ACTIVE-1
//   pixel_y      active row, 0..V_ACTIVE-1
//   pixel_color  {red, green, blue}
//   frame_start  one-cycle pulse coincident with pixel (0,0)
//   locked       line/frame timing verified
//
// Optional build macro VGA_CAPTURE_STATS_EN adds:
//   meas_h_total last measured hsync period (clocks)
//   meas_v_total last measured lines per frame
//   err_count    saturating count of lock losses
//
// Pipeline: pins -> input registers (s_*) -> output registers, so colour
// presented on the pins in cycle N appears on pixel_color in cycle N+2.
// ---------------------------------------------------------------------------
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_color,
  output logic        frame_start,
  output logic        locked
`ifdef VGA_CAPTURE_STATS_EN
  ,
  output logic [9:0]  meas_h_total,
  output logic [9:0]  meas_v_total,
  output logic [7:0]  err_count
`endif
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [9:0] CNT_MAX      = 10'h3FF;
  localparam logic [9:0] H_FIRST      = 10'(H_BACK);
  localparam logic [9:0] H_LAST       = 10'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] V_FIRST      = 10'(V_BACK);
  localparam logic [9:0] V_LAST       = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] H_TOTAL_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_TOTAL_LAST = 10'(V_TOTAL - 1);
  localparam int         GF_W         = $clog2(LOCK_FRAMES + 1) + 1;
  localparam logic [GF_W-1:0] GF_LOCK = GF_W'(LOCK_FRAMES);
  localparam logic [GF_W-1:0] GF_ONE  = GF_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Input stage
  // -------------------------------------------------------------------------
  logic s_hsync_reg;
  logic s_vsync_reg;
  logic s_hsync_d_reg;
  logic s_vsync_d_reg;
  logic [11:0] rgb_in;
  logic [11:0] s_rgb;

  assign rgb_in = {red, green, blue};

  // One register per colour channel; the channels are independent so each
  // gets its own small register block.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [3:0] chan_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          chan_reg <= 4'h0;
        end else begin
          chan_reg <= rgb_in[gi*4 +: 4];
        end
      end
      assign s_rgb[gi*4 +: 4] = chan_reg;
    end
  endgenerate

  // Syncs idle high, so the sampled copies and their delayed versions reset
  // high; this prevents a false rising edge straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_hsync_reg   <= 1'b1;
      s_vsync_reg   <= 1'b1;
      s_hsync_d_reg <= 1'b1;
      s_vsync_d_reg <= 1'b1;
    end else begin
      s_hsync_reg   <= hsync;
      s_vsync_reg   <= vsync;
      s_hsync_d_reg <= s_hsync_reg;
      s_vsync_d_reg <= s_vsync_reg;
    end
  end

  logic hs_rise;
  logic vs_rise;

  assign hs_rise = s_hsync_reg & ~s_hsync_d_reg;
  assign vs_rise = s_vsync_reg & ~s_vsync_d_reg;

  // -------------------------------------------------------------------------
  // Position counters
  //
  // h_cnt_next / v_cnt_next are the coordinates of the sample currently held
  // in the input registers (0 on the rise cycle itself). The _reg copies
  // hold the previous cycle's value, which is what the period checks need:
  // the count on the cycle before a rising edge.
  // -------------------------------------------------------------------------
  logic [9:0] h_cnt_reg;
  logic [9:0] h_cnt_next;
  logic [9:0] v_cnt_reg;
  logic [9:0] v_cnt_next;

  always_comb begin
    h_cnt_next = h_cnt_reg;
    if (hs_rise) begin
      h_cnt_next = 10'd0;
    end else if (h_cnt_reg != CNT_MAX) begin
      h_cnt_next = h_cnt_reg + 10'd1;
    end

    // A vsync rise coinciding with an hsync rise clears the line count.
    v_cnt_next = v_cnt_reg;
    if (vs_rise) begin
      v_cnt_next = 10'd0;
    end else if (hs_rise && (v_cnt_reg != CNT_MAX)) begin
      v_cnt_next = v_cnt_reg + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= 10'd0;
      v_cnt_reg <= 10'd0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Period checks
  // -------------------------------------------------------------------------
  logic skip_first_reg;
  logic skip_first_next;
  logic line_err_reg;
  logic line_err_next;
  logic line_bad;
  logic frame_good;

  // The first line after acquiring vsync may be partial relative to the
  // counter history, so it is excluded from checking.
  assign line_bad   = hs_rise && !skip_first_reg && (h_cnt_reg != H_TOTAL_LAST);
  // The line ending on this very cycle belongs to the frame being closed.
  assign frame_good = !line_err_reg && !line_bad && (v_cnt_reg == V_TOTAL_LAST);

  // -------------------------------------------------------------------------
  // Lock FSM
  // -------------------------------------------------------------------------
  state_t          state_reg;
  state_t          state_next;
  logic [GF_W-1:0] good_frames_reg;
  logic [GF_W-1:0] good_frames_next;
  logic            leave_locked;

  always_comb begin
    state_next       = state_reg;
    good_frames_next = good_frames_reg;
    line_err_next    = line_err_reg;
    skip_first_next  = skip_first_reg;
    if (hs_rise) begin
      skip_first_next = 1'b0;
    end

    case (state_reg)
      ST_SEARCH: begin
        // Arm the skip so the first line seen after leaving is ignored.
        skip_first_next = 1'b1;
        if (vs_rise) begin
          state_next       = ST_MEASURE;
          good_frames_next = '0;
          line_err_next    = 1'b0;
        end
      end

      ST_MEASURE: begin
        if (line_bad) begin
          line_err_next = 1'b1;
        end
        if (vs_rise) begin
          line_err_next = 1'b0;
          if (frame_good) begin
            good_frames_next = good_frames_reg + GF_ONE;
            if ((good_frames_reg + GF_ONE) >= GF_LOCK) begin
              state_next = ST_LOCKED;
            end
          end else begin
            state_next       = ST_SEARCH;
            good_frames_next = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (line_bad || (vs_rise && !frame_good)) begin
          state_next       = ST_SEARCH;
          good_frames_next = '0;
        end
      end

      default: begin
        state_next       = ST_SEARCH;
        good_frames_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_SEARCH;
      good_frames_reg <= '0;
      line_err_reg    <= 1'b0;
      skip_first_reg  <= 1'b1;
    end else begin
      state_reg       <= state_next;
      good_frames_reg <= good_frames_next;
      line_err_reg    <= line_err_next;
      skip_first_reg  <= skip_first_next;
    end
  end

  assign leave_locked = (state_reg == ST_LOCKED) && (state_next != ST_LOCKED);
  assign locked       = (state_reg == ST_LOCKED);

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  logic        active;
  logic        valid_next;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        pixel_valid_reg;
  logic [9:0]  pixel_x_reg;
  logic [9:0]  pixel_y_reg;
  logic [11:0] pixel_color_reg;
  logic        frame_start_reg;

  assign active = (h_cnt_next >= H_FIRST) && (h_cnt_next <= H_LAST) &&
                  (v_cnt_next >= V_FIRST) && (v_cnt_next <= V_LAST);
  assign x_next = h_cnt_next - H_FIRST;
  assign y_next = v_cnt_next - V_FIRST;

  // Pixels stop in the same cycle a timing error is detected, not one later.
  assign valid_next = active && (state_reg == ST_LOCKED) && !leave_locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid_reg <= 1'b0;
      pixel_x_reg     <= 10'd0;
      pixel_y_reg     <= 10'd0;
      pixel_color_reg <= 12'd0;
      frame_start_reg <= 1'b0;
    end else begin
      pixel_valid_reg <= valid_next;
      frame_start_reg <= valid_next && (x_next == 10'd0) && (y_next == 10'd0);
      if (valid_next) begin
        pixel_x_reg     <= x_next;
        pixel_y_reg     <= y_next;
        pixel_color_reg <= s_rgb;
      end
    end
  end

  assign pixel_valid = pixel_valid_reg;
  assign pixel_x     = pixel_x_reg;
  assign pixel_y     = pixel_y_reg;
  assign pixel_color = pixel_color_reg;
  assign frame_start = frame_start_reg;

`ifdef VGA_CAPTURE_STATS_EN
  // -------------------------------------------------------------------------
  // Timing statistics
  // -------------------------------------------------------------------------
  logic [9:0] meas_h_total_reg;
  logic [9:0] meas_v_total_reg;
  logic [7:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meas_h_total_reg <= 10'd0;
      meas_v_total_reg <= 10'd0;
      err_count_reg    <= 8'd0;
    end else begin
      if (hs_rise) begin
        meas_h_total_reg <= h_cnt_reg + 10'd1;
      end
      if (vs_rise) begin
        meas_v_total_reg <= v_cnt_reg + 10'd1;
      end
      if (leave_locked && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign meas_h_total = meas_h_total_reg;
  assign meas_v_total = meas_v_total_reg;
  assign err_count    = err_count_reg;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_capture
//
// Scoreboard bench for vga_capture using a scaled-down raster (28 clocks per
// line, 14 lines per frame) so many frames fit in a short run. The driver
// pushes the expected pixel (coordinates, colour, frame_start, drive cycle)
// for every active pixel it presents while the design is expected to be
// locked; an independent monitor pops and compares on each pixel_valid.
// ---------------------------------------------------------------------------
module tb_vga_capture;

  localparam int HA = 16;
  localparam int HB = 4;
  localparam int HT = 28;
  localparam int VA = 8;
  localparam int VB = 3;
  localparam int VT = 14;
  localparam int LF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  red = 4'h0;
  logic [3:0]  green = 4'h0;
  logic [3:0]  blue = 4'h0;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] pixel_color;
  logic        frame_start;
  logic        locked;
`ifdef VGA_CAPTURE_STATS_EN
  logic [9:0]  meas_h_total;
  logic [9:0]  meas_v_total;
  logic [7:0]  err_count;
`endif

  vga_capture #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hsync(hsync),
    .vsync(vsync),
    .red(red),
    .green(green),
    .blue(blue),
    .pixel_valid(pixel_valid),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_color(pixel_color),
    .frame_start(frame_start),
    .locked(locked)
`ifdef VGA_CAPTURE_STATS_EN
    ,
    .meas_h_total(meas_h_total),
    .meas_v_total(meas_v_total),
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] c;
    logic        fs;
    int          stamp;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp   = 0;
  int n_bad   = 0;
  int n_valid = 0;
  int fs_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drives lines first_line..nlines-1 of one frame. bad_line gets one extra
  // clock; rst is pulsed for one cycle at (rst_line, rst_hp); stuck_h holds
  // hsync high for the whole frame.
  task automatic drive_frame(input string tag, input int nlines, input int first_line,
                             input int bad_line, input bit push, input int rst_line,
                             input int rst_hp, input bit stuck_h);
    bit   pushing;
    bit   act;
    int   len;
    int   x;
    int   y;
    int   pushed;
    exp_t e;
    pushing = push;
    pushed  = 0;
    for (int ln = first_line; ln < nlines; ln++) begin
      len = (ln == bad_line) ? HT + 1 : HT;
      for (int hp = 0; hp < len; hp++) begin
        @(negedge clk);
        rst   = (ln == rst_line) && (hp == rst_hp);
        hsync = stuck_h ? 1'b1 : (hp < len - 4);
        vsync = !(ln >= nlines - 2);
        act   = (hp >= HB) && (hp < HB + HA) && (ln >= VB) && (ln < VB + VA);
        x     = hp - HB;
        y     = ln - VB;
        if (act) {red, green, blue} = {x[3:0], y[3:0], 4'hA};
        else     {red, green, blue} = 12'h5C3;
        // Anything still in the pipeline when rst lands is discarded.
        if ((ln == rst_line) && (hp == rst_hp - 1)) pushing = 1'b0;
        if (act && pushing) begin
          e.x     = x[9:0];
          e.y     = y[9:0];
          e.c     = {x[3:0], y[3:0], 4'hA};
          e.fs    = (x == 0) && (y == 0);
          e.stamp = cyc;
          sb_q.push_back(e);
          pushed++;
        end
        if ((ln == rst_line) && (hp == rst_hp + 1)) begin
          check("rst_mid_valid", 32'(pixel_valid), 32'd0);
          check("rst_mid_locked", 32'(locked), 32'd0);
          check("rst_mid_x", 32'(pixel_x), 32'd0);
          check("rst_mid_y", 32'(pixel_y), 32'd0);
          check("rst_mid_color", 32'(pixel_color), 32'd0);
        end
      end
      if (ln == bad_line) pushing = 1'b0;
    end
    $display("frame %s: lines %0d..%0d bad_line=%0d expected_pixels=%0d locked=%0b",
             tag, first_line, nlines - 1, bad_line, pushed, locked);
  endtask

  // Monitor: every presented pixel must match the oldest expectation and
  // arrive exactly two cycles after it was driven.
  exp_t me;
  always @(negedge clk) begin
    if (pixel_valid) begin
      n_valid++;
      if (frame_start) fs_seen++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d color=%03h at cycle %0d, required no pixel_valid",
                 pixel_x, pixel_y, pixel_color, cyc);
      end else begin
        me = sb_q.pop_front();
        if ((pixel_x !== me.x) || (pixel_y !== me.y) || (pixel_color !== me.c) ||
            (frame_start !== me.fs) || (cyc != me.stamp + 2)) begin
          n_bad++;
          $display("FAIL pixel: got x=%0d y=%0d color=%03h fs=%0b cycle=%0d, required x=%0d y=%0d color=%03h fs=%0b cycle=%0d",
                   pixel_x, pixel_y, pixel_color, frame_start, cyc,
                   me.x, me.y, me.c, me.fs, me.stamp + 2);
        end
      end
    end else if (frame_start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_start_alone: got frame_start=1 with pixel_valid=0, required 0");
    end
  end

  int nv;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(pixel_valid), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_x", 32'(pixel_x), 32'd0);
    check("reset_y", 32'(pixel_y), 32'd0);
    check("reset_color", 32'(pixel_color), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);

    // Acquisition from mid-frame: vsync rise at A, good A and B, lock at C.
    drive_frame("partial", VT, 7, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("A", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    check("locked_after_A", 32'(locked), 32'd0);
    drive_frame("B", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    check("locked_after_B", 32'(locked), 32'd0);
    nv = n_valid;
    drive_frame("C", VT, 0, -1, 1'b1, -1, 0, 1'b0);
    check("locked_in_C", 32'(locked), 32'd1);
    check("pixels_in_C", 32'(n_valid - nv), 32'(HA * VA));
`ifdef VGA_CAPTURE_STATS_EN
    check("meas_h_total", 32'(meas_h_total), 32'(HT));
    check("meas_v_total", 32'(meas_v_total), 32'(VT));
`endif

    // One long line while locked: stream stops after line 5, relock at G.
    drive_frame("D", VT, 0, 5, 1'b1, -1, 0, 1'b0);
    check("locked_after_long_line", 32'(locked), 32'd0);
    drive_frame("E", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("F", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    check("locked_after_F", 32'(locked), 32'd0);
    drive_frame("G", VT, 0, -1, 1'b1, -1, 0, 1'b0);
    check("relocked_in_G", 32'(locked), 32'd1);

    // Second unlock, then a 15-line frame while measuring.
    drive_frame("H", VT, 0, 1, 1'b1, -1, 0, 1'b0);
    check("locked_after_H", 32'(locked), 32'd0);
    drive_frame("I", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("J", VT + 1, 0, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("K", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("L", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("M", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    check("locked_after_M", 32'(locked), 32'd0);

    // Lock at N; N is 15 lines long, so its closing vsync unlocks.
    drive_frame("N", VT + 1, 0, -1, 1'b1, -1, 0, 1'b0);
    check("locked_in_N", 32'(locked), 32'd1);
    drive_frame("O", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    check("locked_after_O", 32'(locked), 32'd0);
`ifdef VGA_CAPTURE_STATS_EN
    check("err_count_3", 32'(err_count), 32'd3);
`endif

    // Relock at R, then a one-cycle reset in the middle of active line y=2.
    drive_frame("P", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    drive_frame("Q", VT, 0, -1, 1'b0, -1, 0, 1'b0);
    nv = n_valid;
    drive_frame("R", VT, 0, -1, 1'b1, 5, 10, 1'b0);
    check("locked_after_R", 32'(locked), 32'd0);
    check("pixels_in_R", 32'(n_valid - nv), 32'd37);
`ifdef VGA_CAPTURE_STATS_EN
    check("err_count_after_rst", 32'(err_count), 32'd0);
`endif

    // hsync stuck high with vsync still toggling.
    drive_frame("S0", VT, 0, -1, 1'b0, -1, 0, 1'b1);
    drive_frame("S1", VT, 0, -1, 1'b0, -1, 0, 1'b1);
    drive_frame("S2", VT, 0, -1, 1'b0, -1, 0, 1'b1);
    check("locked_stuck_hsync", 32'(locked), 32'd0);
    check("h_cnt_saturated", 32'(dut.h_cnt_reg), 32'd1023);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("frame_start_count", 32'(fs_seen), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
